// File: rtl/alu_input_sequencer_if.sv
// Operand-entry bus between the switch/button front end and the ALU input sequencer.
// The master side drives the switches and button; the slave side returns the registered ALU operands.
interface alu_input_sequencer_if #(
  parameter int N = 4
);
  logic [N-1:0] sw;
  logic         btn;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   operator;
  logic         op_valid;
  logic [2:0]   state;
  logic         op_err;
  logic         div_zero;

  modport master (
    output sw, btn,
    input  a, b, operator, op_valid, state, op_err, div_zero
  );

  modport slave (
    input  sw, btn,
    output a, b, operator, op_valid, state, op_err, div_zero
  );
endinterface

// File: rtl/alu_input_sequencer.sv
// Loads operand a, operand b and then the opcode from switches on debounced button presses.
// Presents all three to the ALU as registered values, with a one-cycle op_valid strobe.
module alu_input_sequencer #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_input_sequencer_if.slave   bus
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= 4'd9);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == 4'd3) || (op == 4'd4);
  endfunction

  logic          sync1_r;
  logic          btn_sync_r;
  logic          btn_db_r;
  logic          btn_db_d_r;
  logic [CW-1:0] cnt_r;
  logic          press_s;

  state_t        state_r;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [3:0]    operator_r;
  logic          op_valid_r;
  logic          op_err_r;
  logic          div_zero_r;

  // Button synchronizer, debounce counter and delayed level for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r    <= 1'b0;
      btn_sync_r <= 1'b0;
      btn_db_r   <= 1'b0;
      btn_db_d_r <= 1'b0;
      cnt_r      <= '0;
    end else begin
      sync1_r    <= bus.btn;
      btn_sync_r <= sync1_r;
      btn_db_d_r <= btn_db_r;
      if (btn_sync_r == btn_db_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        btn_db_r <= btn_sync_r;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Only the rising edge of the debounced level counts; releases are ignored.
  assign press_s = btn_db_r & ~btn_db_d_r;

  // Entry FSM; every output is a register written here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_A;
      a_r        <= '0;
      b_r        <= '0;
      operator_r <= 4'd0;
      op_valid_r <= 1'b0;
      op_err_r   <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      op_valid_r <= 1'b0;
      case (state_r)
        S_A: begin
          if (press_s) begin
            a_r     <= bus.sw;
            state_r <= S_B;
          end
        end
        S_B: begin
          if (press_s) begin
            b_r     <= bus.sw;
            state_r <= S_OP;
          end
        end
        S_OP: begin
          if (press_s) begin
            if (is_legal_op(bus.sw[3:0])) begin
              operator_r <= bus.sw[3:0];
              op_err_r   <= 1'b0;
              div_zero_r <= is_div_op(bus.sw[3:0]) && (b_r == '0);
              op_valid_r <= 1'b1;
              state_r    <= S_EXEC;
            end else begin
              op_err_r <= 1'b1;
            end
          end
        end
        // A press landing in the strobe cycle is intentionally dropped.
        S_EXEC: state_r <= S_SHOW;
        S_SHOW: begin
          if (press_s) begin
            div_zero_r <= 1'b0;
            state_r    <= S_A;
          end
        end
        default: state_r <= S_A;
      endcase
    end
  end

  assign bus.a        = a_r;
  assign bus.b        = b_r;
  assign bus.operator = operator_r;
  assign bus.op_valid = op_valid_r;
  assign bus.state    = state_r;
  assign bus.op_err   = op_err_r;
  assign bus.div_zero = div_zero_r;
endmodule

// File: tb/tb_alu_input_sequencer.sv
// Self-checking bench for alu_input_sequencer: table-driven operations with a scoreboard
// checked on op_valid, plus hand sequences for illegal opcodes, hold, bounce and reset.
module tb_alu_input_sequencer;
  localparam int N = 4;
  localparam int D = 4;
  localparam int LAT = D + 3;  // edges counted from the first edge that samples btn high, inclusive

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic       dz;
  } sb_t;

  typedef struct {
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [3:0] op_in;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    logic [3:0] exp_op;
    logic       exp_dz;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic prev_valid = 1'b0;
  sb_t  sb_q[$];
  vec_t vecs[6];

  alu_input_sequencer_if #(.N(N)) bus_if ();

  alu_input_sequencer #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every op_valid strobe must match the oldest queued operation.
  always @(negedge clk) begin
    if (rst_n && bus_if.op_valid) begin
      check("strobe_width", int'(prev_valid), 0);
      check("sb_pending", (sb_q.size() > 0) ? 1 : 0, 1);
      if (sb_q.size() > 0) begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_a", int'(bus_if.a), int'(e.a));
        check("sb_b", int'(bus_if.b), int'(e.b));
        check("sb_op", int'(bus_if.operator), int'(e.op));
        check("sb_dz", int'(bus_if.div_zero), int'(e.dz));
        check("sb_state", int'(bus_if.state), 3);
      end
    end
    prev_valid <= bus_if.op_valid;
  end

  // One clean press; checks capture latency and the resulting state.
  task automatic press(input logic [3:0] v, input logic [2:0] exp_state);
    logic [2:0] prev;
    int n;
    n = 0;
    @(negedge clk);
    bus_if.sw  = v;
    bus_if.btn = 1'b1;
    prev = bus_if.state;
    for (int i = 1; i <= 12 && n == 0; i++) begin
      @(posedge clk); #1;
      if (bus_if.state != prev) n = i;
    end
    if (exp_state != prev) begin
      check("press_latency", n, LAT);
      check("press_state", int'(bus_if.state), int'(exp_state));
      if (exp_state == 3'd3) begin
        check("exec_valid", int'(bus_if.op_valid), 1);
        @(posedge clk); #1;
        check("show_state", int'(bus_if.state), 4);
        check("valid_fall", int'(bus_if.op_valid), 0);
      end
    end else begin
      check("no_move", n, 0);
    end
    @(negedge clk);
    bus_if.btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [3:0] hold_a, hold_b, hold_op;
    logic       hold_dz;
    int n;

    vecs[0] = '{4'd8,  4'd1, 4'd0, 4'd8,  4'd1, 4'd0, 1'b0};
    vecs[1] = '{4'd13, 4'd0, 4'd3, 4'd13, 4'd0, 4'd3, 1'b1};
    vecs[2] = '{4'd13, 4'd0, 4'd2, 4'd13, 4'd0, 4'd2, 1'b0};
    vecs[3] = '{4'd6,  4'd0, 4'd4, 4'd6,  4'd0, 4'd4, 1'b1};
    vecs[4] = '{4'd7,  4'd2, 4'd3, 4'd7,  4'd2, 4'd3, 1'b0};
    vecs[5] = '{4'd15, 4'd15, 4'd9, 4'd15, 4'd15, 4'd9, 1'b0};

    bus_if.sw  = 4'd0;
    bus_if.btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", int'(bus_if.state), 0);
    check("rst_a", int'(bus_if.a), 0);
    check("rst_valid", int'(bus_if.op_valid), 0);
    check("rst_err", int'(bus_if.op_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      press(vecs[i].a_in, 3'd1);
      press(vecs[i].b_in, 3'd2);
      sb_q.push_back('{vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_op, vecs[i].exp_dz});
      press(vecs[i].op_in, 3'd3);
      check("vec_a", int'(bus_if.a), int'(vecs[i].exp_a));
      check("vec_b", int'(bus_if.b), int'(vecs[i].exp_b));
      check("vec_op", int'(bus_if.operator), int'(vecs[i].exp_op));
      check("vec_dz_show", int'(bus_if.div_zero), int'(vecs[i].exp_dz));
      press(4'($urandom_range(15, 0)), 3'd0);
      check("vec_dz_clr", int'(bus_if.div_zero), 0);
      check("vec_a_kept", int'(bus_if.a), int'(vecs[i].exp_a));
    end

    // Illegal opcode is rejected and leaves operator untouched.
    press(4'd5, 3'd1);
    press(4'd6, 3'd2);
    press(4'd12, 3'd2);
    check("ill_err", int'(bus_if.op_err), 1);
    check("ill_state", int'(bus_if.state), 2);
    check("ill_op_kept", int'(bus_if.operator), 9);
    sb_q.push_back('{4'd5, 4'd6, 4'd7, 1'b0});
    press(4'd7, 3'd3);
    check("ill_err_clr", int'(bus_if.op_err), 0);
    check("ill_op_new", int'(bus_if.operator), 7);
    press(4'd0, 3'd0);

    // Hold in S_SHOW while switches wander.
    press(4'd13, 3'd1);
    press(4'd0, 3'd2);
    sb_q.push_back('{4'd13, 4'd0, 4'd4, 1'b1});
    press(4'd4, 3'd3);
    hold_a = bus_if.a; hold_b = bus_if.b; hold_op = bus_if.operator; hold_dz = bus_if.div_zero;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus_if.sw = 4'($urandom_range(15, 0));
    end
    @(negedge clk);
    check("hold_a", int'(bus_if.a), 13);
    check("hold_b", int'(bus_if.b), 0);
    check("hold_op", int'(bus_if.operator), 4);
    check("hold_dz", int'(bus_if.div_zero), 1);
    check("hold_state", int'(bus_if.state), 4);
    press(4'd11, 3'd0);
    check("exit_a", int'(bus_if.a), int'(hold_a));
    check("exit_b", int'(bus_if.b), int'(hold_b));
    check("exit_op", int'(bus_if.operator), int'(hold_op));
    check("exit_dz", int'(bus_if.div_zero), hold_dz ? 0 : 1);

    // Bounce: high 3, low 2, high 3 then held gives exactly one press.
    @(negedge clk);
    bus_if.sw  = 4'd9;
    bus_if.btn = 1'b1;
    repeat (3) @(negedge clk);
    bus_if.btn = 1'b0;
    repeat (2) @(negedge clk);
    check("bounce_idle", int'(bus_if.state), 0);
    bus_if.btn = 1'b1;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(posedge clk); #1;
      if (bus_if.state != 3'd0) n = i;
    end
    check("bounce_latency", n, LAT);
    check("bounce_a", int'(bus_if.a), 9);
    repeat (20) @(posedge clk);
    #1;
    check("bounce_single", int'(bus_if.state), 1);

    // Reset mid-entry with the button held through reset.
    @(negedge clk);
    bus_if.btn = 1'b1;
    bus_if.sw  = 4'd3;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mrst_state", int'(bus_if.state), 0);
    check("mrst_a", int'(bus_if.a), 0);
    check("mrst_b", int'(bus_if.b), 0);
    check("mrst_op", int'(bus_if.operator), 0);
    check("mrst_flags", int'({bus_if.op_valid, bus_if.op_err, bus_if.div_zero}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(posedge clk); #1;
      if (bus_if.state != 3'd0) n = i;
    end
    check("mrst_latency", n, LAT);
    check("mrst_a_cap", int'(bus_if.a), 3);
    @(negedge clk);
    bus_if.btn = 1'b0;
    repeat (10) @(negedge clk);

    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
